// File: rtl/peak_window_capture_pkg.sv
// Shared definitions for the peak window capture path: FSM encoding and pointer sizing.
// The state localparams are public so the output buffer's bench can decode captured state.
package peak_window_capture_pkg;

    localparam logic [1:0] PWC_ST_IDLE    = 2'd0;
    localparam logic [1:0] PWC_ST_COLLECT = 2'd1;
    localparam logic [1:0] PWC_ST_DRAIN   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = PWC_ST_IDLE,
        ST_COLLECT = PWC_ST_COLLECT,
        ST_DRAIN   = PWC_ST_DRAIN
    } pwc_state_e;

    // Bits needed to index 'depth' entries, never less than one.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ring_ram_sdp.sv
// Simple dual-port ring RAM, one write port and one read port with 1-cycle read latency.
// "block" registers the read data; any other style registers the address for LUT RAM.
module ring_ram_sdp
    import peak_window_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 64,
    parameter     MEMORY_TYPE = "block",
    localparam int AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    generate
        if (MEMORY_TYPE == "block") begin : g_block
            logic [DATA_WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk) begin
                if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
                if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
            end
            assign o_rd_data = r_rd_data;
        end else begin : g_dist
            logic [AW-1:0] r_rd_addr;
            always_ff @(posedge clk) begin
                if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
                if (i_rd_en) r_rd_addr <= i_rd_addr;
            end
            assign o_rd_data = r_mem[r_rd_addr];
        end
    endgenerate

endmodule

// File: rtl/peak_window_capture.sv
// Captures PRE+1+POST samples around each tagged peak from a non-stallable stream and
// replays them as one AXI-stream frame through a 2-entry skid buffer.
//   state   | meaning
//   IDLE    | waiting for a peak with enough history in the ring
//   COLLECT | counting down the post-peak samples still to arrive
//   DRAIN   | reading the window out of the ring toward m_axis
module peak_window_capture
    import peak_window_capture_pkg::*;
#(
    parameter int  NUM_TAGS      = 10,
    parameter int  NUM_CHANNELS  = 4,
    parameter int  CHANNEL_WIDTH = 32,
    parameter int  PRE_SAMPLES   = 8,
    parameter int  POST_SAMPLES  = 7,
    parameter int  RING_DEPTH    = 64,
    parameter      MEMORY_TYPE   = "block",
    localparam int DATA_WIDTH    = NUM_CHANNELS * CHANNEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_TAGS-1:0]   s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_TAGS-1:0]   m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [15:0]           drop_count,
    output logic                  overrun
);

    localparam int WINDOW = PRE_SAMPLES + 1 + POST_SAMPLES;
    localparam int AW     = ptr_width(RING_DEPTH);
    localparam int FW     = ptr_width(PRE_SAMPLES + 2);
    localparam int PW     = ptr_width(POST_SAMPLES + 2);
    localparam int CW     = ptr_width(WINDOW + 1);

    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_SAMPLES);
    localparam logic [FW-1:0] FILL_MAX  = FW'(PRE_SAMPLES);
    localparam logic [PW-1:0] POST_INIT = PW'(POST_SAMPLES);
    localparam logic [CW-1:0] RD_TOTAL  = CW'(WINDOW);
    localparam logic [CW-1:0] RD_FINAL  = CW'(WINDOW - 1);

    pwc_state_e            r_state, w_state_nxt;
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [FW-1:0]         r_fill;
    logic [PW-1:0]         r_post_cnt;
    logic [CW-1:0]         r_rd_cnt;
    logic [NUM_TAGS-1:0]   r_tag;
    logic [15:0]           r_drop_count;
    logic                  r_overrun;
    logic                  r_rd_vld, r_rd_last;
    logic [DATA_WIDTH-1:0] r_q0_data, r_q1_data;
    logic                  r_q0_last, r_q1_last;
    logic [1:0]            r_q_cnt;

    logic                  w_peak, w_peak_ok, w_pop, w_rd_en;
    logic [2:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_ram_dout;

    assign w_peak    = s_axis_tvalid && (|s_axis_tuser);
    assign w_peak_ok = w_peak && (r_state == ST_IDLE) && (r_fill == FILL_MAX);
    assign w_pop     = (r_q_cnt != 2'd0) && m_axis_tready;

    // Issue a read only if the skid buffer can absorb it alongside what is already in flight.
    assign w_occ   = {1'b0, r_q_cnt} + {2'b00, r_rd_vld};
    assign w_rd_en = (r_state == ST_DRAIN) && (r_rd_cnt != RD_TOTAL)
                     && ((w_occ - {2'b00, w_pop}) <= 3'd1);

    ring_ram_sdp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (RING_DEPTH),
        .MEMORY_TYPE (MEMORY_TYPE)
    ) u_ring (
        .clk       (clk),
        .i_wr_en   (s_axis_tvalid),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (s_axis_tdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_peak_ok) w_state_nxt = (POST_SAMPLES == 0) ? ST_DRAIN : ST_COLLECT;
            ST_COLLECT: if (s_axis_tvalid && (r_post_cnt == PW'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (w_pop && r_q0_last) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_post_cnt <= '0;
            r_rd_cnt   <= '0;
            r_tag      <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            if (s_axis_tvalid) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (s_axis_tvalid && (r_fill != FILL_MAX)) r_fill <= r_fill + FW'(1);
            if (w_peak_ok) begin
                r_tag      <= s_axis_tuser;
                r_rd_ptr   <= r_wr_ptr - PRE_OFS;
                r_post_cnt <= POST_INIT;
                r_rd_cnt   <= '0;
            end else if ((r_state == ST_COLLECT) && s_axis_tvalid) begin
                r_post_cnt <= r_post_cnt - PW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end
            r_rd_vld  <= w_rd_en;
            r_rd_last <= w_rd_en && (r_rd_cnt == RD_FINAL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (clr) r_drop_count <= '0;
            else if (w_peak && !w_peak_ok && (r_drop_count != 16'hFFFF))
                r_drop_count <= r_drop_count + 16'd1;
            // A write landing just behind the next unread entry means the ring has wrapped onto it.
            if (clr) r_overrun <= 1'b0;
            else if ((r_state == ST_DRAIN) && s_axis_tvalid && (r_rd_cnt != RD_TOTAL)
                     && (r_wr_ptr == (r_rd_ptr - AW'(1))))
                r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0_data <= '0;
            r_q1_data <= '0;
            r_q0_last <= 1'b0;
            r_q1_last <= 1'b0;
            r_q_cnt   <= 2'd0;
        end else begin
            case (r_q_cnt)
                2'd0: if (r_rd_vld) begin
                    r_q0_data <= w_ram_dout;
                    r_q0_last <= r_rd_last;
                    r_q_cnt   <= 2'd1;
                end
                2'd1: if (r_rd_vld && w_pop) begin
                    r_q0_data <= w_ram_dout;
                    r_q0_last <= r_rd_last;
                end else if (w_pop) begin
                    r_q0_last <= 1'b0;
                    r_q_cnt   <= 2'd0;
                end else if (r_rd_vld) begin
                    r_q1_data <= w_ram_dout;
                    r_q1_last <= r_rd_last;
                    r_q_cnt   <= 2'd2;
                end
                2'd2: if (w_pop) begin
                    r_q0_data <= r_q1_data;
                    r_q0_last <= r_q1_last;
                    if (r_rd_vld) begin
                        r_q1_data <= w_ram_dout;
                        r_q1_last <= r_rd_last;
                    end else begin
                        r_q_cnt <= 2'd1;
                    end
                end
                default: r_q_cnt <= 2'd0;
            endcase
        end
    end

    assign m_axis_tvalid = (r_q_cnt != 2'd0);
    assign m_axis_tdata  = r_q0_data;
    assign m_axis_tlast  = r_q0_last;
    assign m_axis_tuser  = r_tag;
    assign drop_count    = r_drop_count;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_peak_window_capture.sv
// Directed bench for peak_window_capture: default ring plus a 32-entry ring for wrap-around.
// Sample n carries data {4{n}}, so every expected beat value follows from the sample index.
module tb_peak_window_capture;

    localparam int DW  = 128;
    localparam int NT  = 10;
    localparam int WIN = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, clr, s_tvalid;
    logic [DW-1:0] s_tdata;
    logic [NT-1:0] s_tuser;
    logic          m_tready, m_tvalid, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [NT-1:0] m_tuser;
    logic [15:0]   drop;
    logic          ovr;
    logic          m32_tready, m32_tvalid, m32_tlast;
    logic [DW-1:0] m32_tdata;
    logic [NT-1:0] m32_tuser;
    logic [15:0]   drop32;
    logic          ovr32;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [NT-1:0] u;
        logic          l;
    } beat_t;

    beat_t q[$];
    beat_t q32[$];

    peak_window_capture u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
        .drop_count(drop), .overrun(ovr)
    );

    peak_window_capture #(.RING_DEPTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m32_tvalid), .m_axis_tready(m32_tready), .m_axis_tdata(m32_tdata),
        .m_axis_tuser(m32_tuser), .m_axis_tlast(m32_tlast),
        .drop_count(drop32), .overrun(ovr32)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int n);
        return {4{32'(n)}};
    endfunction

    // Beat capture and AXI hold-stability check for the default-depth instance.
    logic          p_valid, p_ready, p_last;
    logic [DW-1:0] p_data;
    logic [NT-1:0] p_user;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_ready <= 1'b1;
        end else begin
            if (p_valid && !p_ready) begin
                check_eq("hold_valid", m_tvalid, 1'b1);
                check_eq("hold_data", m_tdata, p_data);
                check_eq("hold_user", m_tuser, p_user);
                check_eq("hold_last", m_tlast, p_last);
            end
            if (m_tvalid && m_tready) q.push_back('{d: m_tdata, u: m_tuser, l: m_tlast});
            if (m32_tvalid && m32_tready) q32.push_back('{d: m32_tdata, u: m32_tuser, l: m32_tlast});
            p_valid <= m_tvalid;
            p_ready <= m_tready;
            p_data  <= m_tdata;
            p_user  <= m_tuser;
            p_last  <= m_tlast;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0;
        m_tready = 1'b1; m32_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        q32.delete();
        rst_n = 1'b1;
    endtask

    task automatic run_samples(input int first, input int last, input int pk1,
                               input logic [NT-1:0] tg1, input int pk2,
                               input logic [NT-1:0] tg2, input bit rnd);
        for (int n = first; n <= last; n++) begin
            s_tvalid = 1'b1;
            s_tdata  = mk(n);
            s_tuser  = (n == pk1) ? tg1 : ((n == pk2) ? tg2 : '0);
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tuser  = '0;
    endtask

    task automatic idle(input int cycles);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int first_n, input logic [NT-1:0] mask);
        check_eq({tag, "_len"}, q.size(), WIN);
        for (int i = 0; i < q.size() && i < WIN; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), q[i].d, mk(first_n + i));
            check_eq($sformatf("%s_user%0d", tag, i), q[i].u, mask);
            check_eq($sformatf("%s_last%0d", tag, i), q[i].l, i == WIN - 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0;
        m_tready = 1'b1; m32_tready = 1'b1;
        #1;
        check_eq("rst_tvalid", m_tvalid, 1'b0);
        check_eq("rst_tlast", m_tlast, 1'b0);
        check_eq("rst_tdata", m_tdata, '0);
        check_eq("rst_tuser", m_tuser, '0);
        check_eq("rst_drop", drop, '0);
        check_eq("rst_overrun", ovr, 1'b0);

        // Single peak on sample 100, ready always high.
        do_reset();
        run_samples(0, 130, 100, 10'h005, -1, '0, 1'b0);
        idle(10);
        check_frame("single", 92, 10'h005);
        check_eq("single_drop", drop, 16'd0);
        check_eq("single_tvalid_end", m_tvalid, 1'b0);

        // Same stimulus, random backpressure.
        do_reset();
        run_samples(0, 140, 100, 10'h005, -1, '0, 1'b1);
        idle(80);
        check_frame("random", 92, 10'h005);
        check_eq("random_overrun", ovr, 1'b0);

        // Second peak during COLLECT is dropped.
        do_reset();
        run_samples(0, 130, 100, 10'h005, 103, 10'h021, 1'b0);
        idle(10);
        check_frame("dropcol", 92, 10'h005);
        check_eq("dropcol_count", drop, 16'd1);
        pulse_clr();
        check_eq("dropcol_clr", drop, 16'd0);

        // Peak before the ring has PRE_SAMPLES of history.
        do_reset();
        run_samples(0, 40, 3, 10'h200, -1, '0, 1'b0);
        idle(10);
        check_eq("early_frames", q.size(), 0);
        check_eq("early_drop", drop, 16'd1);

        // 32-entry ring stalled through DRAIN: overrun, but the frame still completes.
        do_reset();
        m32_tready = 1'b0;
        run_samples(0, 150, 100, 10'h003, -1, '0, 1'b0);
        check_eq("ovr_set", ovr32, 1'b1);
        check_eq("ovr_stall_beats", q32.size(), 0);
        check_eq("ovr_stall_valid", m32_tvalid, 1'b1);
        m32_tready = 1'b1;
        idle(30);
        check_eq("ovr_len", q32.size(), WIN);
        for (int i = 0; i < q32.size() && i < WIN; i++)
            check_eq($sformatf("ovr_last%0d", i), q32[i].l, i == WIN - 1);
        check_eq("ovr_tvalid_end", m32_tvalid, 1'b0);
        check_eq("ovr_sticky", ovr32, 1'b1);
        check_eq("ovr_default_ring", ovr, 1'b0);
        pulse_clr();
        check_eq("ovr_clr", ovr32, 1'b0);

        // Reset in the middle of a frame, then a clean frame afterwards.
        do_reset();
        run_samples(0, 107, 100, 10'h005, -1, '0, 1'b0);
        begin
            int t = 0;
            while (q.size() < 5 && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        check_eq("midrst_beats_seen", q.size() >= 5, 1'b1);
        check_eq("midrst_valid_before", m_tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_tvalid", m_tvalid, 1'b0);
        check_eq("midrst_tlast", m_tlast, 1'b0);
        check_eq("midrst_tdata", m_tdata, '0);
        check_eq("midrst_tuser", m_tuser, '0);
        check_eq("midrst_drop", drop, '0);
        check_eq("midrst_overrun", ovr, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
        run_samples(0, 40, 20, 10'h081, -1, '0, 1'b0);
        idle(10);
        check_frame("postrst", 12, 10'h081);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peak_window_capture.md
# peak_window_capture

Upstream neighbour of the peak-data output buffer. It watches the continuous per-channel correlator sample stream, and on each tagged peak strobe emits a fixed window of samples as one AXI-stream frame: PRE_SAMPLES before the peak, the peak sample itself, and POST_SAMPLES after it. Each frame ends with tlast and carries the tag mask on tuser, ready for the output buffer to serialize toward the MPU.

## Interface
Parameters:
- NUM_TAGS, 10: width of the tag mask.
- NUM_CHANNELS, 4: parallel channels per sample.
- CHANNEL_WIDTH, 32: bits per channel (16 I + 16 Q).
- PRE_SAMPLES, 8: samples captured before the peak (≥0).
- POST_SAMPLES, 7: samples captured after the peak (≥0).
- RING_DEPTH, 64: ring entries. Must be a power of two and ≥ 2·WINDOW.
- MEMORY_TYPE, "block": ring RAM style.
- Derived (localparam): DATA_WIDTH = NUM_CHANNELS·CHANNEL_WIDTH; WINDOW = PRE_SAMPLES+1+POST_SAMPLES.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of drop_count and overrun.
- s_axis_tvalid  in  1  sample valid. There is no tready; the source cannot stall.
- s_axis_tdata  in  DATA_WIDTH  sample.
- s_axis_tuser  in  NUM_TAGS  tag mask. Nonzero with tvalid marks a peak on this sample.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  window sample.
- m_axis_tuser  out  NUM_TAGS  latched tag mask, constant for the whole frame.
- m_axis_tlast  out  1  high on beat WINDOW−1 only.
- drop_count  out  16  saturating count of dropped peaks.
- overrun  out  1  sticky flag: a ring overwrite occurred during a drain.

## Operation
- Every accepted sample (s_axis_tvalid=1) is written to the ring at wr_ptr, then wr_ptr increments modulo RING_DEPTH.
- A fill counter saturates at PRE_SAMPLES. It reaches that value once PRE_SAMPLES samples have been accepted since reset.
- FSM states:
  - IDLE: a peak moves to COLLECT when fill ≥ PRE_SAMPLES. On entry, tag mask is latched, start_ptr = wr_ptr−PRE_SAMPLES (mod RING_DEPTH), post_cnt = POST_SAMPLES.
  - COLLECT: post_cnt decrements per accepted sample. Moves to DRAIN when post_cnt = 0. With POST_SAMPLES=0, the FSM goes directly IDLE→DRAIN.
  - DRAIN: reads WINDOW entries from start_ptr upward. Returns to IDLE after the tlast beat handshakes.
- Dropped peaks:
  - A peak while not in IDLE is dropped and increments drop_count.
  - A peak in IDLE with fill < PRE_SAMPLES is also dropped and counted.
  - drop_count saturates at 0xFFFF.
- Overrun: in DRAIN, if the write address equals start_ptr+RING_DEPTH−1 relative to the next unread entry (i.e. unread data is about to be overwritten), overrun is set.
  - The frame still completes with all WINDOW beats and tlast.
  - Contents of that frame are undefined.
- clr and a simultaneous increment: clr wins, and the count is 0 next cycle.
- Output is a standard AXI-stream source:
  - tdata, tuser and tlast hold stable while tvalid=1 and tready=0.
  - tvalid never drops before the handshake.

## Timing
- Reset values (rst_n=0): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, drop_count=0, overrun=0. Also FSM=IDLE, wr_ptr=0, fill=0.
- Reset mid-frame aborts immediately. No tlast is issued, and downstream sees tvalid fall with reset.
- Ring RAM is simple dual-port with 1-cycle read latency. The output stage is a 2-entry skid buffer, so a read in flight is never lost under backpressure.
- First beat: m_axis_tvalid rises on the 2nd clk edge after the sample that drove post_cnt to 0 is accepted. With POST_SAMPLES=0, this is the 2nd edge after the peak sample.
- Throughput: one beat per clk while m_axis_tready=1, so a full frame takes WINDOW cycles with no stall.
- Peak-to-IDLE: with no stall, the FSM is ready for a new peak exactly 1 cycle after the tlast handshake.
- A peak on that same cycle is dropped.

## Structure
- Shared package/include:
  - existing func_log2.vh for pointer widths;
  - the FSM state encoding (IDLE=0, COLLECT=1, DRAIN=2) as shared localparams, so the output buffer's testbench can decode them.
- Sub-module ring_ram_sdp: parameterized simple dual-port RAM (width DATA_WIDTH, depth RING_DEPTH, MEMORY_TYPE, registered read).
- The FSM, pointers, counters and skid buffer live in the top module.

## Test plan
- Single peak, counting samples, tready=1: peak with tuser=0x005 on sample 100 → 16 beats with data 92…107, tuser=0x005 on every beat, tlast on beat 15 only.
- Random tready at 50%, same stimulus → identical 16-beat sequence, with data stable through every stall.
- Second peak on sample 103 (during COLLECT) → only one frame emitted, drop_count=1. Then pulse clr → drop_count=0.
- Peak on sample 3 after reset (fill<8) → no frame, drop_count=1.
- RING_DEPTH=32 with tready held low for 40 cycles during DRAIN → overrun=1, frame still ends with tlast after 16 beats, overrun stays 1 until clr.
- rst_n asserted at beat 5 of a frame → all outputs 0 asynchronously. After release, a peak on sample 20 yields a correct frame (data 12…27).
